// File: rtl/ysyx_25070198_pkg.sv
// Shared types and constants for the ysyx_25070198 instruction fetch path.
//   ifu_state_t       : prefetch FSM states
//   RESP_OKAY         : read response code for a successful fetch
//   RESET_PC_DEFAULT  : default first fetch address after reset
package ysyx_25070198_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } ifu_state_t;

    localparam logic [1:0]  RESP_OKAY        = 2'b00;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25070198_sync_fifo.sv
// Synchronous FIFO holding fetched instruction entries.
//   clk, rst      : clock and synchronous active-high reset
//   push, wr_data : write an entry (ignored when full)
//   pop           : drop the head entry (ignored when empty)
//   flush         : empty the FIFO; overrides push and pop
//   rd_data       : head entry, valid whenever !empty
//   full, empty   : occupancy flags
//   count         : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module ysyx_25070198_sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            // simultaneous push and pop leaves the occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // storage is data only; its contents are meaningless until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ysyx_25070198_ifu_prefetch.sv
// Instruction prefetch unit: issues one sequential fetch at a time on an
// AXI-like read channel and buffers the results for decode.
//   clk, rst                       : clock, synchronous active-high reset
//   jump, jump_pc                  : redirect request and its target
//   araddr, arvalid, arready       : fetch address channel
//   rdata, rresp, rvalid           : fetch response (always accepted)
//   inst, inst_pc, inst_fault,
//   inst_valid, inst_ready         : decode-side handshake (FIFO head)
module ysyx_25070198_ifu_prefetch
    import ysyx_25070198_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_pc,
    output logic [XLEN-1:0] araddr,
    output logic            arvalid,
    input  logic            arready,
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rvalid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    output logic            inst_valid,
    input  logic            inst_ready
);
    localparam int ENTRY_W = 2 * XLEN + 1;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    ifu_state_t       state, state_n;
    logic [XLEN-1:0]  fetch_pc, fetch_pc_n;
    logic [XLEN-1:0]  req_pc, req_pc_n;
    logic             arvalid_n;
    logic             discard, discard_n;
    logic             push, pop, full, empty;
    logic [CNT_W-1:0] count;
    logic [XLEN-1:0]  jump_target;
    logic [XLEN-1:0]  resp_data;
    logic             resp_ok;
    logic [ENTRY_W-1:0] wr_data, rd_data;
    logic             unused_jump_low;

    // redirect targets are word aligned; the low bits are ignored
    assign jump_target     = {jump_pc[XLEN-1:2], 2'b00};
    assign unused_jump_low = ^jump_pc[1:0];

    assign resp_ok   = (rresp == RESP_OKAY);
    assign resp_data = resp_ok ? rdata : '0;
    assign wr_data   = {!resp_ok, req_pc, resp_data};

    // req_pc stays put while a request is pending, so araddr cannot move
    // even when a jump retargets fetch_pc underneath it
    assign araddr     = req_pc;
    assign inst       = rd_data[XLEN-1:0];
    assign inst_pc    = rd_data[2*XLEN-1:XLEN];
    assign inst_fault = rd_data[2*XLEN];
    assign inst_valid = !empty;
    assign pop        = inst_valid && inst_ready && !jump;

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_pc_n   = req_pc;
        arvalid_n  = arvalid;
        discard_n  = discard;
        push       = 1'b0;

        if (jump) fetch_pc_n = jump_target;

        unique case (state)
            IDLE: begin
                // only one request in flight, so a free slot now is a
                // free slot when its response lands
                if (!jump && count < DEPTH_C) begin
                    state_n   = REQ;
                    arvalid_n = 1'b1;
                    req_pc_n  = fetch_pc;
                end
            end
            REQ: begin
                if (arready) begin
                    state_n   = WAIT;
                    arvalid_n = 1'b0;
                    // a stale request must not advance the redirected pc
                    if (!jump && !discard) fetch_pc_n = fetch_pc + XLEN'(4);
                end
                if (jump) discard_n = 1'b1;
            end
            WAIT: begin
                if (rvalid) begin
                    state_n   = IDLE;
                    discard_n = 1'b0;
                    // a response alongside a jump is already stale
                    if (!jump && !discard) begin
                        push = 1'b1;
                        if (!resp_ok) state_n = FAULT;
                    end
                end else if (jump) begin
                    discard_n = 1'b1;
                end
            end
            FAULT: begin
                if (jump) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            arvalid  <= 1'b0;
            discard  <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            req_pc   <= req_pc_n;
            arvalid  <= arvalid_n;
            discard  <= discard_n;
        end
    end

    ysyx_25070198_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_data),
        .pop     (pop),
        .flush   (jump),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule
